// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and default sizing for the FIFO burst reader and its checker.
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DEF_ADDR_WIDTH  = 9;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_ERR_W       = 4;
  localparam int DEF_TIMEOUT_CYC = 64;
  localparam int RD_LATENCY_MAX  = 4;

endpackage

// File: rtl/fifo_rd_checker.sv
// Tracks reads in flight through the FIFO output latency and compares each
// returned word against the incrementing reference, recording the first miss.
module fifo_rd_checker
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ERR_W      = DEF_ERR_W,
  parameter int RD_LATENCY = 1,
  parameter int START_VAL  = 1
) (
  input  logic                  clk_tb,
  input  logic                  tb_rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  pipe_busy,
  output logic [ERR_W-1:0]      err_cnt,
  output logic [DATA_WIDTH-1:0] first_err_exp,
  output logic [DATA_WIDTH-1:0] first_err_got
);

  if (RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
    $error("fifo_rd_checker: RD_LATENCY out of range");
  end

  logic [RD_LATENCY-1:0] vld_p;
  logic [DATA_WIDTH-1:0] exp_cnt;
  logic                  tap;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  assign tap       = vld_p[RD_LATENCY-1];
  assign pipe_busy = |vld_p;

  // Valid pipe: bit 0 marks an accepted read, the top bit lines up with rd_data.
  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) vld_p <= '0;
    else        vld_p <= RD_LATENCY'({vld_p, push});
  end

  // Compare stage
  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      exp_cnt       <= '0;
      err_cnt       <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (clear) begin
      exp_cnt       <= DATA_WIDTH'(START_VAL);
      err_cnt       <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (tap) begin
      exp_cnt <= exp_cnt + DATA_WIDTH'(1);
      if (rd_data != exp_cnt) begin
        err_cnt <= sat_inc(err_cnt);
        if (err_cnt == '0) begin
          first_err_exp <= exp_cnt;
          first_err_got <= rd_data;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst engine: drains burst_len words through rd_en/empty, aborts
// on a sustained empty stall, and hands returned data to the pattern checker.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int RD_LATENCY  = 1,
  parameter int START_VAL   = 1,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int ERR_W       = DEF_ERR_W
) (
  input  logic                  clk_tb,
  input  logic                  tb_rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   burst_len,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic [ERR_W-1:0]      err_cnt,
  output logic [DATA_WIDTH-1:0] first_err_exp,
  output logic [DATA_WIDTH-1:0] first_err_got
);

  localparam int CNT_W   = ADDR_WIDTH + 1;
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   remaining;
  logic [STALL_W-1:0] stall_cnt;
  logic               launch;
  logic               stall_hit;
  logic               pipe_busy;

  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    launch    = 1'b0;
    stall_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          launch    = 1'b1;
          state_nxt = (burst_len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        rd_en = !empty;
        if (!empty && remaining == CNT_W'(1)) begin
          state_nxt = S_DRAIN;
        end else if (empty && stall_cnt == STALL_W'(TIMEOUT_CYC - 1)) begin
          stall_hit = 1'b1;
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!pipe_busy) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Burst counters; the stall count only advances on empty cycles in READ.
  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      remaining <= '0;
      rd_count  <= '0;
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      if (launch) begin
        remaining <= burst_len;
        rd_count  <= '0;
        stall_cnt <= '0;
        timeout   <= 1'b0;
      end else if (rd_en) begin
        remaining <= remaining - CNT_W'(1);
        rd_count  <= rd_count + CNT_W'(1);
        stall_cnt <= '0;
      end else if (state == S_READ) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
      if (stall_hit) timeout <= 1'b1;
    end
  end

  fifo_rd_checker #(
    .DATA_WIDTH (DATA_WIDTH),
    .ERR_W      (ERR_W),
    .RD_LATENCY (RD_LATENCY),
    .START_VAL  (START_VAL)
  ) u_checker (
    .clk_tb        (clk_tb),
    .tb_rst        (tb_rst),
    .clear         (launch),
    .push          (rd_en),
    .rd_data       (rd_data),
    .pipe_busy     (pipe_busy),
    .err_cnt       (err_cnt),
    .first_err_exp (first_err_exp),
    .first_err_got (first_err_got)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: two instances (read latency 1 and 2),
// each fed by its own behavioural FIFO model sharing one write-stimulus table.
module tb_fifo_burst_reader;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int EW = 4;

  logic          clk_tb = 1'b0;
  logic          tb_rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   burst_len = '0;

  logic          empty1 = 1'b1, empty2 = 1'b1;
  logic [DW-1:0] rd_data1 = '0, rd_data2 = '0, pipe2 = '0;
  logic          rd_en1, busy1, done1, timeout1;
  logic          rd_en2, busy2, done2, timeout2;
  logic [AW:0]   rd_count1, rd_count2;
  logic [EW-1:0] err_cnt1, err_cnt2;
  logic [DW-1:0] fe_exp1, fe_got1, fe_exp2, fe_got2;

  logic [DW-1:0] src_mem [0:1023];
  int            src_len = 0;
  int            wr_div = 1;
  logic          fifo_clr = 1'b1;

  logic [DW-1:0] q1[$], q2[$];
  int            src_rd1 = 0, src_rd2 = 0, pops1 = 0, pops2 = 0;
  int            dones1 = 0, dones2 = 0, bad1 = 0, bad2 = 0;
  logic          tick1 = 1'b0, tick2 = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk_tb = ~clk_tb;

  fifo_burst_reader #(.RD_LATENCY(1)) dut1 (
    .clk_tb(clk_tb), .tb_rst(tb_rst), .start(start), .burst_len(burst_len),
    .empty(empty1), .rd_data(rd_data1), .rd_en(rd_en1), .busy(busy1),
    .done(done1), .timeout(timeout1), .rd_count(rd_count1), .err_cnt(err_cnt1),
    .first_err_exp(fe_exp1), .first_err_got(fe_got1)
  );

  fifo_burst_reader #(.RD_LATENCY(2)) dut2 (
    .clk_tb(clk_tb), .tb_rst(tb_rst), .start(start), .burst_len(burst_len),
    .empty(empty2), .rd_data(rd_data2), .rd_en(rd_en2), .busy(busy2),
    .done(done2), .timeout(timeout2), .rd_count(rd_count2), .err_cnt(err_cnt2),
    .first_err_exp(fe_exp2), .first_err_got(fe_got2)
  );

  // FIFO model, one-cycle read latency
  always @(posedge clk_tb) begin
    if (fifo_clr) begin
      q1.delete(); src_rd1 = 0; pops1 = 0; dones1 = 0; bad1 = 0; tick1 = 1'b0;
      empty1 <= 1'b1;
    end else begin
      if (rd_en1) begin
        pops1++;
        if (q1.size() == 0) bad1++;
        else rd_data1 <= q1.pop_front();
      end
      if (done1) dones1++;
      tick1 = ~tick1;
      if (src_rd1 < src_len && (wr_div == 1 || tick1)) begin
        q1.push_back(src_mem[src_rd1]);
        src_rd1++;
      end
      empty1 <= (q1.size() == 0);
    end
  end

  // FIFO model, two-cycle read latency (output register)
  always @(posedge clk_tb) begin
    if (fifo_clr) begin
      q2.delete(); src_rd2 = 0; pops2 = 0; dones2 = 0; bad2 = 0; tick2 = 1'b0;
      empty2 <= 1'b1;
    end else begin
      if (rd_en2) begin
        pops2++;
        if (q2.size() == 0) bad2++;
        else pipe2 <= q2.pop_front();
      end
      rd_data2 <= pipe2;
      if (done2) dones2++;
      tick2 = ~tick2;
      if (src_rd2 < src_len && (wr_div == 1 || tick2)) begin
        q2.push_back(src_mem[src_rd2]);
        src_rd2++;
      end
      empty2 <= (q2.size() == 0);
    end
  end

  task automatic clr_fifo();
    @(negedge clk_tb);
    fifo_clr = 1'b1;
    src_len  = 0;
    @(negedge clk_tb);
    fifo_clr = 1'b0;
  endtask

  task automatic fill_seq(input int n);
    for (int i = 0; i < n; i++) src_mem[i] = DW'(i + 1);
  endtask

  task automatic wait_written(input int n);
    int t;
    t = 0;
    while ((src_rd1 < n || src_rd2 < n) && t < n + 20) begin
      @(negedge clk_tb);
      t++;
    end
  endtask

  task automatic kick(input int len);
    @(negedge clk_tb);
    start     = 1'b1;
    burst_len = (AW + 1)'(len);
    @(negedge clk_tb);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int t;
    t = 0;
    while ((dones1 == 0 || dones2 == 0) && t < budget) begin
      @(negedge clk_tb);
      t++;
    end
    checks++;
    if (dones1 == 0 || dones2 == 0) begin
      failures++;
      $display("FAIL %s_done_wait: dones1=%0d dones2=%0d after %0d cycles, required done within %0d",
               name, dones1, dones2, t, budget);
    end
    repeat (3) @(negedge clk_tb);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_tb);
    checks++;
    if ({rd_en1, busy1, done1, timeout1, rd_en2, busy2, done2, timeout2} !== 8'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b%b%b%b %b%b%b%b required all 0",
               rd_en1, busy1, done1, timeout1, rd_en2, busy2, done2, timeout2);
    end
    checks++;
    if ({rd_count1, err_cnt1, fe_exp1, fe_got1} !== '0) begin
      failures++;
      $display("FAIL reset_status1: rd_count=%0d err=%0d exp=%h got=%h required 0",
               rd_count1, err_cnt1, fe_exp1, fe_got1);
    end
    checks++;
    if ({rd_count2, err_cnt2, fe_exp2, fe_got2} !== '0) begin
      failures++;
      $display("FAIL reset_status2: rd_count=%0d err=%0d exp=%h got=%h required 0",
               rd_count2, err_cnt2, fe_exp2, fe_got2);
    end
    tb_rst = 1'b0;
  endtask

  task automatic test_full_burst();
    clr_fifo();
    fill_seq(512);
    src_len = 512;
    wait_written(512);
    kick(512);
    repeat (50) @(negedge clk_tb);
    start = 1'b1; burst_len = (AW + 1)'(3);
    @(negedge clk_tb);
    start = 1'b0;
    wait_done(1000, "full");
    checks++;
    if (pops1 != 512 || pops2 != 512) begin
      failures++;
      $display("FAIL full_rd_en_pulses: got %0d/%0d required 512", pops1, pops2);
    end
    checks++;
    if (rd_count1 !== 10'd512 || rd_count2 !== 10'd512) begin
      failures++;
      $display("FAIL full_rd_count: got %0d/%0d required 512", rd_count1, rd_count2);
    end
    checks++;
    if (err_cnt1 !== 4'd0 || err_cnt2 !== 4'd0) begin
      failures++;
      $display("FAIL full_err_cnt: got %0d/%0d required 0 (pattern wraps 255->0)", err_cnt1, err_cnt2);
    end
    checks++;
    if (timeout1 !== 1'b0 || timeout2 !== 1'b0 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL full_flags: timeout=%b/%b busy=%b required 0", timeout1, timeout2, busy1);
    end
    checks++;
    if (dones1 != 1 || dones2 != 1) begin
      failures++;
      $display("FAIL full_done_count: got %0d/%0d required 1", dones1, dones2);
    end
  endtask

  task automatic test_mismatch();
    clr_fifo();
    fill_seq(16);
    src_mem[4] = 8'hAA;
    src_len = 16;
    wait_written(16);
    kick(16);
    wait_done(100, "mismatch");
    checks++;
    if (err_cnt1 !== 4'd1 || err_cnt2 !== 4'd1) begin
      failures++;
      $display("FAIL mismatch_err_cnt: got %0d/%0d required 1", err_cnt1, err_cnt2);
    end
    checks++;
    if (fe_exp1 !== 8'h05 || fe_exp2 !== 8'h05) begin
      failures++;
      $display("FAIL mismatch_first_exp: got %h/%h required 05", fe_exp1, fe_exp2);
    end
    checks++;
    if (fe_got1 !== 8'hAA || fe_got2 !== 8'hAA) begin
      failures++;
      $display("FAIL mismatch_first_got: got %h/%h required aa", fe_got1, fe_got2);
    end
  endtask

  task automatic test_saturate();
    clr_fifo();
    for (int i = 0; i < 20; i++) src_mem[i] = 8'h00;
    src_len = 20;
    wait_written(20);
    kick(20);
    wait_done(100, "saturate");
    checks++;
    if (err_cnt1 !== 4'hF || err_cnt2 !== 4'hF) begin
      failures++;
      $display("FAIL saturate_err_cnt: got %0d/%0d required 15", err_cnt1, err_cnt2);
    end
    checks++;
    if (fe_exp1 !== 8'h01 || fe_got1 !== 8'h00) begin
      failures++;
      $display("FAIL saturate_first: exp=%h got=%h required exp=01 got=00", fe_exp1, fe_got1);
    end
  endtask

  task automatic test_stall();
    clr_fifo();
    fill_seq(12);
    src_len = 8;
    wait_written(8);
    kick(12);
    repeat (20) @(negedge clk_tb);
    checks++;
    if (busy1 !== 1'b1 || rd_count1 !== 10'd8) begin
      failures++;
      $display("FAIL stall_mid: busy=%b rd_count=%0d required busy=1 rd_count=8", busy1, rd_count1);
    end
    src_len = 12;
    wait_done(200, "stall");
    checks++;
    if (rd_count1 !== 10'd12 || rd_count2 !== 10'd12) begin
      failures++;
      $display("FAIL stall_rd_count: got %0d/%0d required 12", rd_count1, rd_count2);
    end
    checks++;
    if (err_cnt1 !== 4'd0 || timeout1 !== 1'b0 || timeout2 !== 1'b0) begin
      failures++;
      $display("FAIL stall_status: err=%0d timeout=%b/%b required 0", err_cnt1, timeout1, timeout2);
    end
    checks++;
    if (bad1 != 0 || bad2 != 0 || pops1 != 12) begin
      failures++;
      $display("FAIL stall_rd_en_empty: reads-on-empty=%0d/%0d pulses=%0d required 0/0/12",
               bad1, bad2, pops1);
    end
  endtask

  task automatic test_toggle();
    clr_fifo();
    wr_div = 2;
    fill_seq(6);
    kick(6);
    src_len = 6;
    wait_done(100, "toggle");
    wr_div = 1;
    checks++;
    if (rd_count1 !== 10'd6 || pops1 != 6 || pops2 != 6) begin
      failures++;
      $display("FAIL toggle_reads: rd_count=%0d pulses=%0d/%0d required 6", rd_count1, pops1, pops2);
    end
    checks++;
    if (err_cnt1 !== 4'd0 || err_cnt2 !== 4'd0 || bad1 != 0) begin
      failures++;
      $display("FAIL toggle_err: err=%0d/%0d reads-on-empty=%0d required 0", err_cnt1, err_cnt2, bad1);
    end
  endtask

  task automatic test_timeout();
    clr_fifo();
    fill_seq(3);
    src_len = 3;
    wait_written(3);
    kick(10);
    wait_done(200, "timeout");
    checks++;
    if (timeout1 !== 1'b1 || timeout2 !== 1'b1) begin
      failures++;
      $display("FAIL timeout_flag: got %b/%b required 1", timeout1, timeout2);
    end
    checks++;
    if (rd_count1 !== 10'd3 || rd_count2 !== 10'd3) begin
      failures++;
      $display("FAIL timeout_rd_count: got %0d/%0d required 3", rd_count1, rd_count2);
    end
    checks++;
    if (dones1 != 1 || err_cnt1 !== 4'd0) begin
      failures++;
      $display("FAIL timeout_done: dones=%0d err=%0d required 1 and 0", dones1, err_cnt1);
    end
  endtask

  task automatic test_zero_len();
    clr_fifo();
    kick(0);
    checks++;
    if (done1 !== 1'b1 || done2 !== 1'b1) begin
      failures++;
      $display("FAIL zero_done_now: got %b/%b required 1", done1, done2);
    end
    @(negedge clk_tb);
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL zero_done_single: done=%b busy=%b required 0", done1, busy1);
    end
    wait_done(10, "zero");
    checks++;
    if (pops1 != 0 || rd_count1 !== 10'd0 || dones1 != 1) begin
      failures++;
      $display("FAIL zero_reads: pulses=%0d rd_count=%0d dones=%0d required 0/0/1",
               pops1, rd_count1, dones1);
    end
  endtask

  task automatic test_back_to_back();
    int t;
    clr_fifo();
    fill_seq(512);
    src_len = 512;
    wait_written(512);
    kick(512);
    t = 0;
    while (pops1 < 100 && t < 400) begin
      @(negedge clk_tb);
      t++;
    end
    checks++;
    if (rd_count1 !== 10'd100) begin
      failures++;
      $display("FAIL midrst_pre_count: got %0d required 100", rd_count1);
    end
    tb_rst = 1'b1;
    #1;
    checks++;
    if ({rd_en1, busy1, done1, timeout1, rd_en2, busy2} !== 6'b0) begin
      failures++;
      $display("FAIL midrst_ctrl: got %b%b%b%b%b%b required all 0",
               rd_en1, busy1, done1, timeout1, rd_en2, busy2);
    end
    checks++;
    if ({rd_count1, rd_count2, err_cnt1, err_cnt2} !== '0) begin
      failures++;
      $display("FAIL midrst_status: rd_count=%0d/%0d err=%0d/%0d required 0",
               rd_count1, rd_count2, err_cnt1, err_cnt2);
    end
    repeat (2) @(negedge clk_tb);
    tb_rst = 1'b0;
    clr_fifo();
    fill_seq(64);
    src_len = 64;
    wait_written(64);
    kick(64);
    wait_done(200, "rerun");
    checks++;
    if (rd_count2 !== 10'd64 || err_cnt2 !== 4'd0 || timeout2 !== 1'b0) begin
      failures++;
      $display("FAIL rerun_lat2: rd_count=%0d err=%0d timeout=%b required 64/0/0",
               rd_count2, err_cnt2, timeout2);
    end
    checks++;
    if (rd_count1 !== 10'd64 || err_cnt1 !== 4'd0) begin
      failures++;
      $display("FAIL rerun_lat1: rd_count=%0d err=%0d required 64/0", rd_count1, err_cnt1);
    end
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_mismatch();
    test_saturate();
    test_stall();
    test_toggle();
    test_timeout();
    test_zero_len();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
